// File: rtl/ddr_chk_pkg.sv
// Shared types and data-pattern helpers for the DDR traffic checker.
// DDR_CHK_LFSR_EN selects an LFSR pattern; otherwise the pattern is an incrementing count.
package ddr_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT
    } state_t;

    // Right-shifting Galois tap masks giving maximal-length sequences.
    localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return LFSR_TAPS_8;
            32:      return LFSR_TAPS_32;
            64:      return LFSR_TAPS_64;
            default: return LFSR_TAPS_16;
        endcase
    endfunction

    function automatic logic [63:0] pattern_init(input logic [63:0] seed);
`ifdef DDR_CHK_LFSR_EN
        return seed | 64'd1;
`else
        return seed;
`endif
    endfunction

    function automatic logic [63:0] pattern_next(input logic [63:0] cur, input int width);
        logic [63:0] mask;
        logic [63:0] nxt;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
`ifdef DDR_CHK_LFSR_EN
        nxt = cur >> 1;
        if (cur[0]) nxt = nxt ^ lfsr_taps(width);
`else
        nxt = cur + 64'd1;
`endif
        return nxt & mask;
    endfunction

endpackage

// File: rtl/ddr_traffic_checker_pattern.sv
// Pattern word generator: load starts a sequence from seed, step advances one word.
module ddr_pattern_gen
    import ddr_chk_pkg::*;
#(
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [DATA_BITS-1:0] seed,
    output logic [DATA_BITS-1:0] word
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (load) begin
            word <= DATA_BITS'(pattern_init(64'(seed)));
        end else if (step) begin
            word <= DATA_BITS'(pattern_next(64'(word), DATA_BITS));
        end
    end

endmodule

// File: rtl/ddr_traffic_checker.sv
// Periodic DDR write/read-back traffic generator with on-the-fly data checking.
// Build with DDR_CHK_LFSR_EN for LFSR data patterns (default: incrementing pattern).
module ddr_traffic_checker
    import ddr_chk_pkg::*;
#(
    parameter int ADDR_BITS      = 25,
    parameter int DATA_BITS      = 16,
    parameter int NUM_REGIONS    = 4,
    parameter int REGION_STRIDE  = 100_000,
    parameter int XFER_LEN       = 4096,
    parameter int PERIOD_CYCLES  = 200_000_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic                 wr_start,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [ADDR_BITS-1:0] wr_len,
    input  logic                 wr_en,
    output logic [DATA_BITS-1:0] wr_data,
    input  logic                 wr_finish,
    output logic                 rd_start,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic [ADDR_BITS-1:0] rd_len,
    input  logic                 rd_en,
    input  logic [DATA_BITS-1:0] rd_data,
    input  logic                 rd_finish,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          err_cnt,
    output logic [ADDR_BITS-1:0] first_err_addr,
    output logic                 len_err,
    output logic                 timeout,
    output logic                 busy
);

    localparam int IDX_W  = $clog2(NUM_REGIONS);
    localparam int IDX_VW = (IDX_W > 0) ? IDX_W : 1;
    localparam int PER_W  = $clog2(PERIOD_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_BITS-1:0] LEN    = ADDR_BITS'(XFER_LEN);
    localparam logic [ADDR_BITS-1:0] STRIDE = ADDR_BITS'(REGION_STRIDE);

    state_t               state;
    logic [IDX_VW-1:0]    idx;
    logic [PER_W-1:0]     period_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [ADDR_BITS-1:0] rd_cnt;
    logic [ADDR_BITS-1:0] rd_cnt_next;
    logic [ADDR_BITS-1:0] base;
    logic [DATA_BITS-1:0] seed;
    logic [DATA_BITS-1:0] exp_word;
    logic                 period_done;
    logic                 tmo_hit;
    logic                 rd_hit;
    logic                 mismatch;

    assign base        = ADDR_BITS'(idx) * STRIDE;
    assign seed        = DATA_BITS'((32'(pass_cnt[7:0]) << IDX_W) | 32'(idx));
    assign period_done = (period_cnt == PER_W'(PERIOD_CYCLES - 1));
    assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign rd_hit      = (state == ST_RD_WAIT) && rd_en;
    assign mismatch    = rd_hit && (rd_data != exp_word);
    assign rd_cnt_next = rd_cnt + ADDR_BITS'(rd_hit);

    ddr_pattern_gen #(.DATA_BITS(DATA_BITS)) u_wr_pat (
        .clk  (clk),
        .rst_n(rst_n),
        .load (state == ST_WR_REQ),
        .step ((state == ST_WR_WAIT) && wr_en),
        .seed (seed),
        .word (wr_data)
    );

    ddr_pattern_gen #(.DATA_BITS(DATA_BITS)) u_exp_pat (
        .clk  (clk),
        .rst_n(rst_n),
        .load (state == ST_RD_REQ),
        .step (rd_hit),
        .seed (seed),
        .word (exp_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            period_cnt     <= '0;
            tmo_cnt        <= '0;
            rd_cnt         <= '0;
            wr_start       <= 1'b0;
            wr_addr        <= '0;
            wr_len         <= '0;
            rd_start       <= 1'b0;
            rd_addr        <= '0;
            rd_len         <= '0;
            pass_cnt       <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            len_err        <= 1'b0;
            timeout        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // Period runs from pass start to pass start, so overlong passes restart at once.
            if (state == ST_IDLE || (state == ST_WAIT && period_done))
                period_cnt <= '0;
            else if (!period_done)
                period_cnt <= period_cnt + PER_W'(1);

            if (mismatch) begin
                if (err_cnt == '0) first_err_addr <= base + rd_cnt;
                if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (period_done) begin
                        state <= ST_WR_REQ;
                        busy  <= 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    wr_addr  <= base;
                    wr_len   <= LEN;
                    wr_start <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (wr_finish || tmo_hit) begin
                        wr_start <= 1'b0;
                        wr_addr  <= '0;
                        wr_len   <= '0;
                        if (wr_finish) begin
                            state <= ST_RD_REQ;
                        end else begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_WAIT;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_RD_REQ: begin
                    rd_addr  <= base;
                    rd_len   <= LEN;
                    rd_start <= 1'b1;
                    rd_cnt   <= '0;
                    tmo_cnt  <= '0;
                    state    <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (rd_finish) begin
                        rd_start <= 1'b0;
                        if (rd_cnt_next != LEN) len_err <= 1'b1;
                        pass_cnt <= pass_cnt + 16'd1;
                        if (32'(idx) == NUM_REGIONS - 1) idx <= '0;
                        else                             idx <= idx + IDX_VW'(1);
                        busy  <= 1'b0;
                        state <= enable ? ST_WAIT : ST_IDLE;
                    end else if (tmo_hit) begin
                        rd_start <= 1'b0;
                        timeout  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_WAIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        rd_cnt  <= rd_cnt_next;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_traffic_checker.sv
// Directed/randomized bench for ddr_traffic_checker with a loopback memory and pattern model.
module tb_ddr_traffic_checker;

    localparam int XFER = 8;
    localparam int NREG = 4;
    localparam int STRD = 16;

    logic        clk = 1'b0;
    logic        rst_n, enable, wr_en, wr_finish, rd_en, rd_finish;
    logic [15:0] rd_data;
    logic        wr_start, rd_start, len_err, timeout, busy;
    logic [24:0] wr_addr, wr_len, rd_addr, rd_len, first_err_addr;
    logic [15:0] wr_data, pass_cnt, err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state derived from the behavioural rules
    int          m_pass, m_idx, m_err;
    logic [31:0] m_first;
    bit          m_len, m_tmo;
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    ddr_traffic_checker #(
        .ADDR_BITS(25), .DATA_BITS(16), .NUM_REGIONS(NREG), .REGION_STRIDE(STRD),
        .XFER_LEN(XFER), .PERIOD_CYCLES(100), .TIMEOUT_CYCLES(200)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len), .wr_en(wr_en),
        .wr_data(wr_data), .wr_finish(wr_finish),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_en(rd_en),
        .rd_data(rd_data), .rd_finish(rd_finish),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .len_err(len_err), .timeout(timeout), .busy(busy)
    );

    function automatic logic [15:0] pat_first(input logic [15:0] s);
`ifdef DDR_CHK_LFSR_EN
        return s | 16'd1;
`else
        return s;
`endif
    endfunction

    function automatic logic [15:0] pat_step(input logic [15:0] v);
`ifdef DDR_CHK_LFSR_EN
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
`else
        return v + 16'd1;
`endif
    endfunction

    function automatic logic [15:0] m_seed();
        return 16'((m_pass % 256) * NREG + m_idx);
    endfunction

    function automatic logic [31:0] m_base();
        return 32'(m_idx * STRD);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // which: 0 = wr_start, 1 = rd_start
    task automatic wait_for(input int which, input string tag);
        for (int i = 0; i < 400; i++) begin
            if ((which == 0 && wr_start) || (which == 1 && rd_start)) return;
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $error("FAIL %s observed=no_start expected=start_within_400_cycles", tag);
        finish_run();
    endtask

    task automatic model_reset();
        m_pass = 0; m_idx = 0; m_err = 0; m_first = 0; m_len = 0; m_tmo = 0;
    endtask

    task automatic check_state(input string tag);
        $display("[TB] %s: pass_cnt=%0d err_cnt=%0d first_err_addr=%0d len_err=%0b timeout=%0b",
                 tag, pass_cnt, err_cnt, first_err_addr, len_err, timeout);
        check("pass_cnt", 32'(pass_cnt), 32'(m_pass % 65536));
        check("err_cnt", 32'(err_cnt), (m_err > 65535) ? 32'hFFFF : 32'(m_err));
        check("first_err_addr", 32'(first_err_addr), m_first);
        check("len_err", 32'(len_err), 32'(m_len));
        check("timeout", 32'(timeout), 32'(m_tmo));
    endtask

    task automatic do_write(input int n_en, input bit finish);
        logic [15:0] exp_w;
        int a;
        check("wr_addr", 32'(wr_addr), m_base());
        check("wr_len", 32'(wr_len), XFER);
        check("busy_pass", 32'(busy), 1);
        exp_w = pat_first(m_seed());
        a = int'(wr_addr);
        for (int k = 0; k < n_en; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_en = 1'b0;
                @(negedge clk);
            end
            wr_en = 1'b1;
            check("wr_data", 32'(wr_data), 32'(exp_w));
            mem[(a + k) & 255] = wr_data;
            exp_w = pat_step(exp_w);
            @(negedge clk);
        end
        wr_en = 1'b0;
        if (finish) begin
            wr_finish = 1'b1;
            @(negedge clk);
            wr_finish = 1'b0;
            check("wr_start_drop", 32'(wr_start), 0);
            check("wr_addr_clear", 32'(wr_addr), 0);
        end
    endtask

    task automatic do_read(input int n_en, input int flip, input bit corrupt);
        logic [15:0] exp_r, d;
        int a;
        bit comb;
        wait_for(1, "rd_start");
        check("rd_addr", 32'(rd_addr), m_base());
        check("rd_len", 32'(rd_len), XFER);
        a = int'(rd_addr);
        exp_r = pat_first(m_seed());
        comb = 1'($urandom_range(0, 1));
        for (int k = 0; k < n_en; k++) begin
            if (!corrupt && $urandom_range(0, 3) == 0) begin
                rd_en = 1'b0;
                @(negedge clk);
            end
            d = corrupt ? (exp_r ^ 16'd1) : mem[(a + k) & 255];
            if (k == flip) d = d ^ 16'd1;
            if (d != exp_r) begin
                if (m_err == 0) m_first = 32'(a + k);
                m_err++;
            end
            rd_en = 1'b1;
            rd_data = d;
            rd_finish = comb && (k == n_en - 1);
            exp_r = pat_step(exp_r);
            @(negedge clk);
        end
        rd_en = 1'b0;
        if (!rd_finish) begin
            rd_finish = 1'b1;
            @(negedge clk);
        end
        rd_finish = 1'b0;
        if (n_en != XFER) m_len = 1;
        m_pass++;
        m_idx = (m_idx + 1) % NREG;
    endtask

    initial begin
        int cyc;
        bit seen;
        rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_finish = 1'b0;
        rd_en = 1'b0; rd_finish = 1'b0; rd_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_wr_start", 32'(wr_start), 0);
        check("rst_rd_start", 32'(rd_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check_state("reset");
        rst_n = 1'b1;
        enable = 1'b1;

        // Five loopback passes, bit 0 of word 3 flipped in the first
        for (int p = 0; p < 5; p++) begin
            wait_for(0, "wr_start");
            $display("[TB] pass %0d wr_addr=%0d", m_pass, wr_addr);
            do_write(XFER, 1'b1);
            do_read(XFER, (p == 0) ? 3 : -1, 1'b0);
            check("busy_idle", 32'(busy), 0);
            check_state("clean_pass");
        end

        // Short read: seven words then finish
        wait_for(0, "wr_start");
        do_write(XFER, 1'b1);
        do_read(XFER - 1, -1, 1'b0);
        check_state("short_read");

        // Write never finishes: timeout, then retry at the same region
        wait_for(0, "wr_start");
        check("tmo_wr_addr", 32'(wr_addr), m_base());
        cyc = 0;
        while (!timeout && cyc < 260) begin
            if (cyc == 190) check("timeout_early", 32'(timeout), 0);
            @(negedge clk);
            cyc++;
        end
        m_tmo = 1;
        $display("[TB] timeout after %0d cycles", cyc);
        check("timeout_window", 32'(cyc >= 195 && cyc <= 205), 1);
        check("tmo_wr_start", 32'(wr_start), 0);
        check_state("after_timeout");
        wait_for(0, "wr_start_retry");
        do_write(XFER, 1'b1);
        do_read(XFER, -1, 1'b0);
        check_state("retry_pass");

        // Enable dropped mid-pass: pass completes, then idle
        wait_for(0, "wr_start");
        enable = 1'b0;
        do_write(XFER, 1'b1);
        do_read(XFER, -1, 1'b0);
        check_state("disable_pass");
        seen = 0;
        for (int i = 0; i < 250; i++) begin
            if (wr_start || busy) seen = 1;
            @(negedge clk);
        end
        check("idle_no_pass", 32'(seen), 0);
        enable = 1'b1;

        // Asynchronous reset in the middle of a read
        wait_for(0, "wr_start");
        do_write(XFER, 1'b1);
        wait_for(1, "rd_start");
        for (int k = 0; k < 3; k++) begin
            rd_en = 1'b1;
            rd_data = mem[(int'(rd_addr) + k) & 255] ^ 16'hFFFF;
            @(negedge clk);
        end
        rd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_rd_start", 32'(rd_start), 0);
        check("arst_busy", 32'(busy), 0);
        check_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_for(0, "wr_start");
        do_write(XFER, 1'b1);
        do_read(XFER, -1, 1'b0);
        check_state("post_reset");

        // Drive more than 0xFFFF mismatching words; err_cnt must saturate
        while (m_err < 65546) begin
            wait_for(0, "wr_start");
            do_write(XFER, 1'b1);
            do_read(190, -1, 1'b1);
        end
        check_state("saturation");
        check("err_sat", 32'(err_cnt), 32'hFFFF);

        finish_run();
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=no_finish expected=finish_before_100000_cycles");
        $fatal(1, "bench time limit expired");
    end

endmodule
